// File: rtl/output_unit.sv
// 64-point FFT output stage: 8x8-lane digit-reversed frame in, 64 natural-order samples out; sample 0 two edges after beat 7.
// Ping-pong banks; in_ready drops only while both banks hold unsent frames; no output backpressure.
module output_unit #(
    parameter int DW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] dinre,
    input  logic [8*DW-1:0] dinim,
    output logic            dout_valid,
    output logic [DW-1:0]   doutre,
    output logic [DW-1:0]   doutim,
    output logic            dout_last
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [DW-1:0] r_mem_re [0:1][0:63];
    logic [DW-1:0] r_mem_im [0:1][0:63];

    state_t        r_state;
    logic [1:0]    r_full;
    logic          r_wb;
    logic          r_rb;
    logic [2:0]    r_wcnt;
    logic [5:0]    r_rcnt;
    logic          r_dout_valid;
    logic          r_dout_last;
    logic [DW-1:0] r_doutre;
    logic [DW-1:0] r_doutim;

    logic          w_wr_en;
    logic [5:0]    w_raddr;
    logic [DW-1:0] w_rd_re;
    logic [DW-1:0] w_rd_im;

    assign in_ready = !r_full[r_wb];
    assign w_wr_en  = in_valid && in_ready;

    // Entries are stored as {beat, lane}; natural bin n lives at beat n%8, lane n/8.
    assign w_raddr = {r_rcnt[2:0], r_rcnt[5:3]};
    assign w_rd_re = r_mem_re[r_rb][w_raddr];
    assign w_rd_im = r_mem_im[r_rb][w_raddr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int j = 0; j < 8; j++) begin
                r_mem_re[r_wb][{r_wcnt, 3'(j)}] <= dinre[DW*j +: DW];
                r_mem_im[r_wb][{r_wcnt, 3'(j)}] <= dinim[DW*j +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_full       <= 2'b00;
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
            r_wcnt       <= 3'd0;
            r_rcnt       <= 6'd0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_doutre     <= '0;
            r_doutim     <= '0;
        end else begin
            if (w_wr_en) begin
                r_wcnt <= r_wcnt + 3'd1;
                if (r_wcnt == 3'd7) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_dout_valid <= 1'b0;
                    r_dout_last  <= 1'b0;
                    if (r_full[r_rb])
                        r_state <= S_SEND;
                end
                S_SEND: begin
                    r_doutre     <= w_rd_re;
                    r_doutim     <= w_rd_im;
                    r_dout_valid <= 1'b1;
                    r_dout_last  <= (r_rcnt == 6'd63);
                    r_rcnt       <= r_rcnt + 6'd1;
                    if (r_rcnt == 6'd63) begin
                        r_full[r_rb] <= 1'b0;
                        r_rb         <= ~r_rb;
                        // A frame already waiting in the other bank streams out with no gap.
                        if (!r_full[~r_rb])
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign doutre     = r_doutre;
    assign doutim     = r_doutim;

endmodule

// File: tb/tb_output_unit.sv
// Bench for output_unit: directed frames plus random frames checked against a queue-based reference.
module tb_output_unit;

    localparam int DW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*DW-1:0] dinre = '0;
    logic [8*DW-1:0] dinim = '0;
    logic            dout_valid;
    logic [DW-1:0]   doutre;
    logic [DW-1:0]   doutim;
    logic            dout_last;

    output_unit #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dinre      (dinre),
        .dinim      (dinim),
        .dout_valid (dout_valid),
        .doutre     (doutre),
        .doutim     (doutim),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            n;
        int            start;
    } smp_t;

    smp_t          exp_q[$];
    smp_t          mon_e;
    int            frames_in  = 0;
    int            frames_out = 0;
    int            last_end   = -1000;
    logic [DW-1:0] frm_re [64];
    logic [DW-1:0] frm_im [64];

    // Reference: a frame occupies a bank from its last beat until its bin 63 leaves;
    // each frame starts at the later of (last beat + 2) and (previous frame end + 1).
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_vld", 32'(dout_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("dout_re", 32'(doutre), 32'(mon_e.re));
                    check_val("dout_im", 32'(doutim), 32'(mon_e.im));
                    check_val("dout_last", 32'(dout_last), 32'(mon_e.n == 63));
                    if (mon_e.n == 0)
                        check_val("start_cyc", 32'(cyc),
                                  32'((mon_e.start > last_end + 1) ? mon_e.start : last_end + 1));
                    if (mon_e.n == 63) begin
                        last_end = cyc;
                        frames_out++;
                    end
                end
            end else begin
                check_val("idle_last", 32'(dout_last), 32'd0);
            end
            check_val("in_ready", 32'(in_ready), 32'((frames_in - frames_out) < 2));
        end
    end

    task automatic set_conv(input int f);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) begin
                frm_re[k*8+j] = DW'((8*j + k + 64*f) % 1024);
                frm_im[k*8+j] = DW'(1023 - (8*j + k));
            end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 64; i++) begin
            frm_re[i] = DW'($urandom);
            frm_im[i] = DW'($urandom);
        end
    endtask

    task automatic push_frame(input int e);
        smp_t s;
        for (int n = 0; n < 64; n++) begin
            s.re    = frm_re[(n % 8) * 8 + n / 8];
            s.im    = frm_im[(n % 8) * 8 + n / 8];
            s.n     = n;
            s.start = e + 2;
            exp_q.push_back(s);
        end
        frames_in++;
    endtask

    // Called at a negedge; idle gap cycles are inserted before beats 3 and 6.
    task automatic send_frame(input int nbeats, input int gap);
        for (int k = 0; k < nbeats; k++) begin
            int t;
            t = 0;
            if ((k == 3 || k == 6) && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            for (int j = 0; j < 8; j++) begin
                dinre[DW*j +: DW] = frm_re[k*8+j];
                dinim[DW*j +: DW] = frm_im[k*8+j];
            end
            in_valid = 1'b1;
            while (!in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check_val("rdy_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (k == 7) push_frame(cyc);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("rst_vld", 32'(dout_valid), 32'd0);
        check_val("rst_re", 32'(doutre), 32'd0);
        check_val("rst_im", 32'(doutim), 32'd0);
        check_val("rst_last", 32'(dout_last), 32'd0);
        check_val("rst_rdy", 32'(in_ready), 32'd1);
        exp_q.delete();
        frames_in  = 0;
        frames_out = 0;
        last_end   = -1000;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int t;
        do_reset();

        set_conv(0);
        send_frame(8, 0);
        wait_drain();

        set_conv(0);
        send_frame(8, 3);
        wait_drain();

        for (int f = 0; f < 3; f++) begin
            set_conv(f);
            send_frame(8, 0);
        end
        wait_drain();

        set_conv(0);
        send_frame(8, 0);
        t = 0;
        while (exp_q.size() > 44 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("mid_out_reach", 32'(exp_q.size()), 32'd44);
        do_reset();
        repeat (10) @(negedge clk);
        set_conv(1);
        send_frame(8, 0);
        wait_drain();

        set_conv(2);
        send_frame(5, 0);
        do_reset();
        set_conv(3);
        send_frame(8, 0);
        wait_drain();

        for (int r = 0; r < 8; r++) begin
            set_rand();
            send_frame(8, $urandom_range(0, 4));
            repeat ($urandom_range(0, 70)) @(negedge clk);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/output_unit.md
Name: output_unit

Overview:
- Parallel-to-serial output stage of the 64-point FFT; mirror of input_unit.
- Accepts one 64-sample complex frame from the FFT core as 8 beats of 8 lanes, in radix-8 digit-reversed order.
- Emits the frame serially in natural bin order, one sample per clock, as 64 consecutive valid cycles.
- Ping-pong buffered: the core can deliver the next frame while the current one streams out.

Parameters:
- DW, 10, bit width of each real/imaginary component.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  beat from FFT core is valid
- in_ready  output  1  block can accept a beat this cycle
- dinre  input  8*DW  real parts; lane j at bits [DW*j+DW-1:DW*j]
- dinim  input  8*DW  imaginary parts, same packing
- dout_valid  output  1  serial sample valid
- doutre  output  DW  serial real part
- doutim  output  DW  serial imaginary part
- dout_last  output  1  high with bin 63 of each frame

Behaviour:
- Clock and reset: clk; rst_n is asynchronous, active-low.
- Reset values:
  - dout_valid=0, doutre=0, doutim=0, dout_last=0.
  - Both banks empty; write bank wb=0, read bank rb=0.
  - Beat counter wcnt=0, read counter rcnt=0.
  - in_ready=1 once rst_n deasserts.
- Storage: two banks (0/1), each 64 entries of re/im DW bits, plus a full flag per bank.
- Write side:
  - in_ready = !full[wb] (combinational).
  - Beat accepted on a rising edge when in_valid && in_ready.
  - Lane j of beat k is written to entry (k, j) of bank wb.
  - wcnt[2:0] increments per accepted beat; beats need not be contiguous.
  - On acceptance of beat 7: full[wb] set, wb toggles, wcnt wraps to 0.
- Ordering: lane j of beat k holds bin X[8*j+k]. Output sample n comes from beat n%8, lane n/8.
- Read FSM, states IDLE and SEND:
  - IDLE -> SEND when full[rb]=1.
  - In SEND, each edge registers sample rcnt of bank rb onto doutre/doutim, sets dout_valid=1, and sets dout_last=(rcnt==63). rcnt then increments.
  - On the edge that outputs rcnt=63: full[rb] cleared, rb toggles, rcnt wraps to 0.
  - If the other bank is already full, stay in SEND and output its sample 0 on the next edge (gapless). Otherwise go to IDLE, and dout_valid=0 from the next edge.
- In IDLE, dout_valid=0, dout_last=0, and doutre/doutim hold their last values.
- Latency:
  - Beat 7 accepted at edge E: full flag visible after E, FSM enters SEND at E+1.
  - Sample 0 is therefore registered out at edge E+2.
  - dout_last is high on the output cycle after edge E+65.
- Throughput: one frame per 64 cycles. in_ready drops while both banks are full, and rises the cycle after the edge that releases a bank.
- Simultaneous events: a write into one bank and the release of the other bank on the same edge are independent. A write can never target the bank being read, because writes only go to non-full banks and reads only from full banks.
- No output backpressure: the downstream consumer must accept every valid cycle.
- Reset mid-operation: partial input frame and any in-progress output are discarded, and all state returns to reset values. No dout_valid until a full new frame arrives.
- Data passes through unmodified; no scaling or rounding.

Test Plan:
- Stimulus convention for all frames: beat k, lane j has re=8*j+k and im=1023-(8*j+k).
- Single frame:
  - Stimulus: 8 contiguous beats after reset.
  - Required: dout_valid high exactly 64 cycles, starting 2 edges after beat 7. Output n has re=n, im=1023-n; dout_last only at n=63.
- Gapped input:
  - Stimulus: the same frame with in_valid low for 3 cycles between beats 2 and 3, and between beats 5 and 6.
  - Required: output identical to the single-frame case, shifted later by 6 cycles.
- Back-to-back and backpressure:
  - Stimulus: 3 frames offered continuously, frame f using re=(8*j+k)+64*f mod 1024.
  - Required: in_ready low after frame 1 completes while bank 0 is still draining. 192 contiguous dout_valid cycles with no gap. Output re sequence is 0..191 (mod 1024).
- Reset mid-output:
  - Stimulus: assert rst_n low while rcnt=20, then release.
  - Required: all outputs go to 0 immediately and in_ready=1. No dout_valid until a new 8-beat frame; that frame is output correctly from n=0.
- Reset mid-input:
  - Stimulus: 5 beats, then reset, then a full fresh frame.
  - Required: only the fresh frame appears on the output, with correct ordering.
